// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared definitions for the ALU scheduler.
//   - aluctrl opcode constants
//   - scheduler FSM state encoding
//   - is_multicycle(): true for opcodes whose ALU inputs must be held
//     stable for MULDIV_CYCLES cycles (MUL, DIV)
package alu_sched_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd10;
    localparam logic [3:0] OP_SLT = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] ctrl);
        return (ctrl == OP_MUL) || (ctrl == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_sched_arbiter.sv
// alu_rr_arbiter: combinational round-robin pick.
//   valid  in   NREQ  request vector
//   ptr    in   IW    highest-priority requester this cycle
//   grant  out  NREQ  one-hot grant (all zero when nothing valid)
//   idx    out  IW    index of the granted requester
//   any    out  1     at least one request valid
module alu_rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int          pos;
    logic [IW-1:0] pos_idx;

    // Scan from ptr upwards with wrap; first valid requester wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            pos_idx = IW'(pos);
            if (!any && valid[pos_idx]) begin
                any          = 1'b1;
                grant[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one W-bit ALU between NREQ requesters, one op in flight.
//   clk, reset_n             clock, async active-low reset
//   req_valid/ready/a/b/ctrl per-requester op interface (packed per requester)
//   rsp_valid/ready/id/data/zero/err  shared tagged response
//   alu_a/alu_b/alu_ctrl     registered drive to the ALU
//   alu_out/alu_zero         ALU result
//   busy                     scheduler not idle
// Optional build macro DIVZERO_TRAP_EN: DIV by zero is trapped locally
// (all-ones result, rsp_err=1) instead of being issued to the ALU.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational this cycle
// EXEC  | first cycle loads alu_*, then hold until cnt reaches 0
// RESP  | result registered, held until rsp_ready
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int W             = 32,
    parameter int MULDIV_CYCLES = 4,
    localparam int IW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [W-1:0]      alu_out,
    input  logic              alu_zero,
    output logic              busy
);

    localparam int            CW     = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MD = CW'(MULDIV_CYCLES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic          issued_q;
    logic [W-1:0]  op_a_q, op_b_q;
    logic [3:0]    op_ctrl_q;
    logic [IW-1:0] op_id_q;
    logic          op_trap_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            gany;
    logic [W-1:0]    sel_a, sel_b;
    logic [3:0]      sel_ctrl;
    logic            sel_trap;

    alu_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign sel_a    = req_a[int'(gidx)*W +: W];
    assign sel_b    = req_b[int'(gidx)*W +: W];
    assign sel_ctrl = req_ctrl[int'(gidx)*4 +: 4];

`ifdef DIVZERO_TRAP_EN
    assign sel_trap = (sel_ctrl == OP_DIV) && (sel_b == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err <= 1'b0;
        end else if (state_q == ST_EXEC && issued_q && cnt_q == '0) begin
            rsp_err <= op_trap_q;
        end else if (state_q == ST_RESP && rsp_ready) begin
            rsp_err <= 1'b0;
        end
    end
`else
    assign sel_trap = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gany) state_d = ST_EXEC;
            ST_EXEC: if (issued_q && cnt_q == '0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) ? grant : '0;
        busy      = (state_q != ST_IDLE);
    end

    // The first EXEC cycle only loads alu_*; the result is sampled no earlier
    // than one full cycle later, so the ALU path starts at a register and the
    // grant mux never feeds the ALU combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            issued_q  <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_ctrl_q <= '0;
            op_id_q   <= '0;
            op_trap_q <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gany) begin
                        op_a_q    <= sel_a;
                        op_b_q    <= sel_b;
                        op_ctrl_q <= sel_ctrl;
                        op_id_q   <= gidx;
                        op_trap_q <= sel_trap;
                        issued_q  <= 1'b0;
                        cnt_q     <= (is_multicycle(sel_ctrl) && !sel_trap) ? CNT_MD : '0;
                        if (gidx == IW'(NREQ - 1)) ptr_q <= '0;
                        else                       ptr_q <= gidx + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!issued_q) begin
                        issued_q <= 1'b1;
                        if (!op_trap_q) begin
                            alu_a    <= op_a_q;
                            alu_b    <= op_b_q;
                            alu_ctrl <= op_ctrl_q;
                        end
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= op_id_q;
                        rsp_data  <= op_trap_q ? '1 : alu_out;
                        rsp_zero  <= op_trap_q ? 1'b0 : alu_zero;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched (NREQ=2, W=32,
// MULDIV_CYCLES=4) with a behavioural ALU attached to alu_*.
module tb_alu_sched;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_sched #(.NREQ(2), .W(32), .MULDIV_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd4:    alu_out = alu_a * alu_b;
            4'd5:    alu_out = (alu_b == 32'd0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            4'd10:   alu_out = alu_a - alu_b;
            4'd11:   alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic set_req(input int r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_ctrl[r*4 +: 4] = c;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 2'b00;
        req_a = '0;
        req_b = '0;
        req_ctrl = '0;
        rsp_ready = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            $display("FAIL reset_status: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
        end else pass_cnt++;
        total_cnt++;
        if ({alu_a, alu_b, alu_ctrl} !== 68'd0) begin
            $display("FAIL reset_alu: a=%h b=%h ctrl=%h expected 0", alu_a, alu_b, alu_ctrl);
        end else pass_cnt++;
        total_cnt++;
        if (req_ready !== 2'b00 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
            $display("FAIL reset_rsp: req_ready=%b data=%h err=%b expected 00 0 0", req_ready, rsp_data, rsp_err);
        end else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        int n;
        set_req(0, 4'd2, 32'd5, 32'hFFFF_FFFD);
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL single_grant: req_ready=%b expected 01", req_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 2'b00 || busy !== 1'b1) begin
            $display("FAIL single_ready_pulse: req_ready=%b busy=%b expected 00 1", req_ready, busy);
        end else pass_cnt++;
        req_valid = 2'b00;
        wait_rsp(n);
        total_cnt++;
        if (n !== 2) $display("FAIL single_latency: got %0d edges expected 2", n);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 32'd2 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            $display("FAIL single_rsp: data=%h id=%0d zero=%b expected 2 0 0", rsp_data, rsp_id, rsp_zero);
        end else pass_cnt++;
        accept_rsp();
        total_cnt++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL single_release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end else pass_cnt++;
    endtask

    task automatic test_mul_latency();
        int n;
        set_req(1, 4'd4, 32'd6, 32'd7);
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            total_cnt++;
            if ({alu_a, alu_b, alu_ctrl} !== {32'd6, 32'd7, 4'd4}) begin
                $display("FAIL mul_alu_stable[%0d]: a=%h b=%h ctrl=%h expected 6 7 4", n, alu_a, alu_b, alu_ctrl);
            end else pass_cnt++;
        end
        total_cnt++;
        if (n !== 5) $display("FAIL mul_latency: got %0d edges expected 5", n);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 32'd42 || rsp_id !== 1'b1) begin
            $display("FAIL mul_rsp: data=%0d id=%0d expected 42 1", rsp_data, rsp_id);
        end else pass_cnt++;
        accept_rsp();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] exp_d[4] = '{32'h0000_F000, 32'd0, 32'h0000_F000, 32'd0};
        logic [1:0]  gseq[4];
        logic [0:0]  ids[4];
        logic [31:0] dats[4];
        int gcnt = 0;
        int rcnt = 0;
        for (int i = 0; i < 4; i++) begin
            gseq[i] = 2'b11;
            ids[i] = 1'bx;
            dats[i] = 32'hDEAD_BEEF;
        end
        set_req(0, 4'd0, 32'h0000_F0F0, 32'h0000_FF00);
        set_req(1, 4'd0, 32'h0000_000F, 32'h0000_00F0);
        rsp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (req_ready !== 2'b00 && gcnt < 4) begin
                gseq[gcnt] = req_ready;
                gcnt++;
            end
            if (rsp_valid === 1'b1 && rcnt < 4) begin
                ids[rcnt] = rsp_id;
                dats[rcnt] = rsp_data;
                rcnt++;
            end
            if (rcnt == 4) break;
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (gseq[i] !== exp_g[i]) $display("FAIL rr_grant[%0d]: got %b expected %b", i, gseq[i], exp_g[i]);
            else pass_cnt++;
            total_cnt++;
            if (ids[i] !== exp_g[i][1]) $display("FAIL rr_id[%0d]: got %0d expected %0d", i, ids[i], exp_g[i][1]);
            else pass_cnt++;
            total_cnt++;
            if (dats[i] !== exp_d[i]) $display("FAIL rr_data[%0d]: got %h expected %h", i, dats[i], exp_d[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        set_req(0, 4'd10, 32'd10, 32'd3);
        set_req(1, 4'd11, 32'hFFFF_FFFF, 32'd1);
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL bp_first_grant: req_ready=%b expected 01", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(n);
        total_cnt++;
        if (n !== 2) $display("FAIL bp_latency: got %0d edges expected 2", n);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_zero, req_ready} !== {1'b1, 1'b0, 32'd7, 1'b0, 2'b00}) begin
                $display("FAIL bp_hold[%0d]: valid=%b id=%0d data=%h zero=%b req_ready=%b expected 1 0 7 0 00",
                         i, rsp_valid, rsp_id, rsp_data, rsp_zero, req_ready);
            end else pass_cnt++;
        end
        accept_rsp();
        total_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 0 10", rsp_valid, req_ready);
        end else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(n);
        total_cnt++;
        if (rsp_data !== 32'd1 || rsp_id !== 1'b1) begin
            $display("FAIL bp_second: data=%h id=%0d expected 1 1", rsp_data, rsp_id);
        end else pass_cnt++;
        accept_rsp();
    endtask

    task automatic test_div_zero();
        int n;
        set_req(0, 4'd5, 32'd9, 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(n);
`ifdef DIVZERO_TRAP_EN
        total_cnt++;
        if (n !== 2) $display("FAIL div0_latency: got %0d edges expected 2", n);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 32'hFFFF_FFFF || rsp_err !== 1'b1 || rsp_zero !== 1'b0) begin
            $display("FAIL div0_rsp: data=%h err=%b zero=%b expected ffffffff 1 0", rsp_data, rsp_err, rsp_zero);
        end else pass_cnt++;
        total_cnt++;
        if (alu_ctrl !== 4'd11) $display("FAIL div0_not_issued: alu_ctrl=%0d expected 11", alu_ctrl);
        else pass_cnt++;
`else
        total_cnt++;
        if (n !== 5) $display("FAIL div0_latency: got %0d edges expected 5", n);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 32'hFFFF_FFFF || rsp_err !== 1'b0) begin
            $display("FAIL div0_rsp: data=%h err=%b expected ffffffff 0", rsp_data, rsp_err);
        end else pass_cnt++;
        total_cnt++;
        if (alu_ctrl !== 4'd5) $display("FAIL div0_issued: alu_ctrl=%0d expected 5", alu_ctrl);
        else pass_cnt++;
`endif
        accept_rsp();
        total_cnt++;
        if (rsp_err !== 1'b0) $display("FAIL div0_err_clear: err=%b expected 0", rsp_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_exec();
        int n;
        set_req(0, 4'd4, 32'd3, 32'd5);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || alu_ctrl !== 4'd4) begin
            $display("FAIL rst_pre: busy=%b alu_ctrl=%0d expected 1 4", busy, alu_ctrl);
        end else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, rsp_valid, alu_a, alu_b, alu_ctrl} !== 70'd0) begin
            $display("FAIL rst_async: busy=%b valid=%b a=%h b=%h ctrl=%h expected all 0",
                     busy, rsp_valid, alu_a, alu_b, alu_ctrl);
        end else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        set_req(0, 4'd2, 32'd1, 32'd1);
        set_req(1, 4'd4, 32'd3, 32'd5);
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL rst_ptr_zero: req_ready=%b expected 01", req_ready);
        else pass_cnt++;
        req_valid[0] = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 2'b10) $display("FAIL rst_skip_dropped: req_ready=%b expected 10", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(n);
        total_cnt++;
        if (n !== 5 || rsp_data !== 32'd15 || rsp_id !== 1'b1) begin
            $display("FAIL rst_new_op: edges=%0d data=%0d id=%0d expected 5 15 1", n, rsp_data, rsp_id);
        end else pass_cnt++;
        accept_rsp();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_final_idle: busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_mul_latency();
        test_round_robin();
        test_backpressure();
        test_div_zero();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
